// File: rtl/prog_mem_loader_pkg.sv
// Shared encodings and default widths for the program memory / boot loader.
package prog_mem_loader_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;
endpackage

// File: rtl/prog_ram.sv
// 2**ADDR_W x DATA_W RAM: synchronous write, combinational read, synchronous clear.
module prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (clr)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // Same-address read during a write returns the old word until the edge.
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_mem_loader.sv
// Boot loader + program RAM: streams an image in, holds the CPU in clear, then releases it.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              cpu_clr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] memoryOut,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [3:0]        hold_cnt;
  logic              hs, hs_end;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              unused_read;

  assign unused_read = read;

  assign load_ready = (state == ST_LOAD);
  assign cpu_clr    = (state != ST_RUN);
  assign hs         = load_valid & load_ready;
  // Final address ends the load even without load_last, so wr_ptr never wraps into mem[0].
  assign hs_end     = hs & (load_last | (wr_ptr == {ADDR_W{1'b1}}));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (hs_end)           state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == 4'd0) state_nxt = ST_RUN;
      ST_RUN:  if (reload)           state_nxt = ST_LOAD;
      default:                       state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_LOAD;
      wr_ptr     <= '0;
      load_count <= '0;
      hold_cnt   <= '0;
      load_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= hs_end;
      if (hs) begin
        wr_ptr     <= wr_ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
      if (state == ST_RUN && reload) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end
      if (hs_end)
        hold_cnt <= 4'(HOLD_CYCLES - 1);
      else if (state == ST_HOLD && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Write port belongs to the loader in LOAD and to the CPU in RUN; HOLD writes nothing.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = address;
    ram_wdata = memoryIn;
    if (state == ST_LOAD) begin
      ram_we    = hs;
      ram_waddr = wr_ptr;
      ram_wdata = load_data;
    end else if (state == ST_RUN) begin
      ram_we    = write;
    end
  end

  prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .clr   (clr),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (address),
    .rdata (memoryOut)
  );
endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: spec-level model checked every cycle plus literal pins.
module tb_prog_mem_loader;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       clr, load_valid, load_last, reload, write, read;
  logic [7:0] load_data, memoryIn, memoryOut;
  logic [3:0] address;
  logic       load_ready, cpu_clr, load_done;
  logic [4:0] load_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: mode 0=loading, 1=holding, 2=running.
  int         m_mode, m_hold, m_ptr, m_cnt;
  bit         m_done;
  logic [7:0] m_mem [16];

  always #5 clk = ~clk;

  prog_mem_loader #(.ADDR_W(4), .DATA_W(8), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .clr(clr), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .reload(reload),
    .cpu_clr(cpu_clr), .address(address), .memoryIn(memoryIn), .write(write),
    .read(read), .memoryOut(memoryOut), .load_done(load_done),
    .load_count(load_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_done = 0;
    if (clr) begin
      m_mode = 0; m_hold = 0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      case (m_mode)
        0: if (load_valid) begin
             m_mem[m_ptr] = load_data;
             m_ptr++; m_cnt++;
             if (load_last || m_ptr == 16) begin
               m_mode = 1; m_hold = HOLD; m_done = 1;
             end
           end
        1: begin
             m_hold--;
             if (m_hold == 0) m_mode = 2;
           end
        default: begin
             if (write) m_mem[address] = memoryIn;
             if (reload) begin m_mode = 0; m_ptr = 0; m_cnt = 0; end
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", {31'd0, load_ready}, {31'd0, m_mode == 0});
      chk("m_cpuclr", {31'd0, cpu_clr}, {31'd0, m_mode != 2});
      chk("m_done", {31'd0, load_done}, {31'd0, m_done});
      chk("m_count", {27'd0, load_count}, m_cnt);
      chk("m_memout", {24'd0, memoryOut}, {24'd0, m_mem[address]});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input int a, input logic [7:0] exp);
    address = 4'(a);
    #1;
    chk($sformatf("mem[%0d]", a), {24'd0, memoryOut}, {24'd0, exp});
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    tick();
    load_valid = 0; load_last = 0;
  endtask

  initial begin
    clr = 1; load_valid = 0; load_data = 0; load_last = 0; reload = 0;
    write = 0; read = 0; address = 0; memoryIn = 0;
    tick(); chk_en = 1; tick();
    chk("rst_ready", {31'd0, load_ready}, 1);
    chk("rst_cpuclr", {31'd0, cpu_clr}, 1);
    chk("rst_count", {27'd0, load_count}, 0);
    chk("rst_done", {31'd0, load_done}, 0);
    clr = 0;

    // Three-byte image
    send(8'h37, 0); send(8'h54, 0); send(8'h54, 1);
    chk("img3_done", {31'd0, load_done}, 1);
    chk("img3_count", {27'd0, load_count}, 3);
    chk("img3_hold1", {31'd0, cpu_clr}, 1);
    tick();
    chk("img3_done_drop", {31'd0, load_done}, 0);
    chk("img3_hold2", {31'd0, cpu_clr}, 1);
    tick();
    chk("img3_run", {31'd0, cpu_clr}, 0);
    peek(0, 8'h37); peek(1, 8'h54); peek(2, 8'h54); peek(3, 8'h00); peek(15, 8'h00);

    // CPU write in RUN: old value before the edge, new value after
    address = 4; memoryIn = 8'hA5; write = 1; #1;
    chk("wr_before", {24'd0, memoryOut}, 8'h00);
    tick(); write = 0; #1;
    chk("wr_after", {24'd0, memoryOut}, 8'hA5);

    // Reload; CPU writes during LOAD and HOLD are ignored
    reload = 1; tick(); reload = 0;
    chk("reload_ready", {31'd0, load_ready}, 1);
    chk("reload_count", {27'd0, load_count}, 0);
    address = 2; memoryIn = 8'hFF; write = 1; tick(); write = 0;
    send(8'h11, 1);
    address = 2; write = 1; tick(); tick(); write = 0;
    chk("rl_run", {31'd0, cpu_clr}, 0);
    peek(0, 8'h11); peek(1, 8'h54); peek(2, 8'h54); peek(4, 8'hA5);

    // Full 16-byte image without load_last; valid stays high past the end
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1; load_data = 8'(i); load_last = 0; tick();
    end
    chk("full_ready", {31'd0, load_ready}, 0);
    chk("full_count", {27'd0, load_count}, 16);
    chk("full_done", {31'd0, load_done}, 1);
    load_data = 8'hEE; tick(); tick(); load_valid = 0; tick();
    chk("full_run", {31'd0, cpu_clr}, 0);
    peek(0, 8'h00); peek(7, 8'h07); peek(15, 8'h0F);

    // clr mid-load, coincident with a handshake
    reload = 1; tick(); reload = 0;
    send(8'h55, 0); send(8'h66, 0);
    load_valid = 1; load_data = 8'h99; clr = 1; tick();
    clr = 0; load_valid = 0;
    chk("abort_count", {27'd0, load_count}, 0);
    chk("abort_ready", {31'd0, load_ready}, 1);
    chk("abort_cpuclr", {31'd0, cpu_clr}, 1);
    peek(0, 8'h00); peek(1, 8'h00); peek(2, 8'h00); peek(15, 8'h00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
